// File: rtl/spi_poll_seq_if.sv
// Bundle of the sequencer's SPI-side and result-side signals.
// Suffixes are from the sequencer's point of view: _i enters it, _o leaves it.
interface spi_poll_seq_if;
    logic        en_i;
    logic        spi_start_o;
    logic [7:0]  spi_txdata_o;
    logic [7:0]  spi_rxdata1_i;
    logic [7:0]  spi_rxdata2_i;
    logic [15:0] res_data_o;
    logic [1:0]  res_ch_o;
    logic        res_valid_o;
    logic        res_ready_i;
    logic        overrun_o;
    logic        clr_ovr_i;
    logic        busy_o;

    // Sequencer side.
    modport master (
        input  en_i,
        input  spi_rxdata1_i,
        input  spi_rxdata2_i,
        input  res_ready_i,
        input  clr_ovr_i,
        output spi_start_o,
        output spi_txdata_o,
        output res_data_o,
        output res_ch_o,
        output res_valid_o,
        output overrun_o,
        output busy_o
    );

    // Controller / SPI-engine side.
    modport slave (
        output en_i,
        output spi_rxdata1_i,
        output spi_rxdata2_i,
        output res_ready_i,
        output clr_ovr_i,
        input  spi_start_o,
        input  spi_txdata_o,
        input  res_data_o,
        input  res_ch_o,
        input  res_valid_o,
        input  overrun_o,
        input  busy_o
    );
endinterface

// File: rtl/spi_poll_seq.sv
// Round-robin command sequencer for the spi_msb master: pulses START, times the
// transfer with a cycle counter, then queues the two-byte reply in a 2-entry FIFO.
module spi_poll_seq #(
    parameter int unsigned NCH          = 4,
    parameter logic [7:0]  CMD_BASE     = 8'h54,
    parameter int unsigned START_CYCLES = 5,
    parameter int unsigned XFER_CYCLES  = 6100,
    parameter int unsigned GAP_CYCLES   = 1000
) (
    input  logic           clk_i,
    input  logic           rst_i,
    spi_poll_seq_if.master bus
);
    localparam logic [15:0] START_LAST = 16'(START_CYCLES - 1);
    localparam logic [15:0] XFER_LAST  = 16'(XFER_CYCLES - 1);
    localparam logic [15:0] GAP_LAST   = 16'(GAP_CYCLES - 1);
    localparam logic [1:0]  CH_LAST    = 2'(NCH - 1);
    localparam int unsigned DEPTH      = 2;
    localparam logic [1:0]  DEPTH_C    = 2'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_WAIT,
        ST_CAPTURE,
        ST_GAP
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [1:0]  ch_q, ch_d;
    logic [7:0]  txdata_q, txdata_d;
    logic        push;

    // ------------------------------------------------------------------
    // Transaction sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ch_q     <= '0;
            txdata_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ch_q     <= ch_d;
            txdata_q <= txdata_d;
        end
    end

    // cnt_q counts from the first START cycle through WAIT, so the transfer
    // time is measured from the start of the pulse, not from its end.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ch_d     = ch_q;
        txdata_d = txdata_q;
        push     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.en_i) begin
                    state_d  = ST_START;
                    cnt_d    = '0;
                    txdata_d = CMD_BASE + {6'd0, ch_q};
                end
            end
            ST_START: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q >= START_LAST) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q >= XFER_LAST) begin
                    state_d = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                push    = 1'b1;
                ch_d    = (ch_q == CH_LAST) ? 2'd0 : ch_q + 2'd1;
                cnt_d   = '0;
                state_d = ST_GAP;
            end
            ST_GAP: begin
                cnt_d = cnt_q + 16'd1;
                if (cnt_q >= GAP_LAST) begin
                    cnt_d = '0;
                    if (bus.en_i) begin
                        state_d  = ST_START;
                        txdata_d = CMD_BASE + {6'd0, ch_q};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Result FIFO: slot 0 is always the head, so outputs need no read mux.
    // ------------------------------------------------------------------
    logic [17:0] mem_q [DEPTH];
    logic [17:0] mem_d [DEPTH];
    logic [1:0]  count_q, count_d;
    logic        ovr_q, ovr_d;
    logic        pop;
    logic        push_ok;
    logic        ovr_set;
    logic [1:0]  wr_idx;
    logic [17:0] wr_entry;

    assign pop      = (count_q != 2'd0) && bus.res_ready_i;
    assign push_ok  = push && ((count_q < DEPTH_C) || pop);
    assign ovr_set  = push && (count_q == DEPTH_C) && !pop;
    assign wr_idx   = count_q - {1'b0, pop};
    assign wr_entry = {bus.spi_rxdata1_i, bus.spi_rxdata2_i, ch_q};

    // Each slot either takes the new entry, shifts down on a pop, or holds.
    genvar gi;
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
        logic [17:0] shifted;
        if (gi < DEPTH - 1) begin : g_shift
            assign shifted = mem_q[gi + 1];
        end else begin : g_last
            assign shifted = mem_q[gi];
        end
        assign mem_d[gi] = (push_ok && (wr_idx == 2'(gi))) ? wr_entry :
                           (pop ? shifted : mem_q[gi]);
    end

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop) begin
            count_d = count_q + 2'd1;
        end else if (pop && !push_ok) begin
            count_d = count_q - 2'd1;
        end
    end

    // A fresh overrun outranks a clear arriving in the same cycle.
    assign ovr_d = ovr_set ? 1'b1 : (bus.clr_ovr_i ? 1'b0 : ovr_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            count_q <= '0;
            ovr_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            count_q <= count_d;
            ovr_q   <= ovr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.spi_start_o  = (state_q == ST_START);
    assign bus.spi_txdata_o = txdata_q;
    assign bus.res_data_o   = mem_q[0][17:2];
    assign bus.res_ch_o     = mem_q[0][1:0];
    assign bus.res_valid_o  = (count_q != 2'd0);
    assign bus.overrun_o    = ovr_q;
    assign bus.busy_o       = (state_q != ST_IDLE);
endmodule
